// File: rtl/vai_rd_arbiter.sv
// vai_rd_arbiter: c0 read-request arbiter and response router for the VAI mux layer.
// Each sub-AFU has a skid FIFO, an address offset and an outstanding-read credit limit.
// Requests are granted round-robin and tagged with the AFU index in the top mdata bits.
// Responses are routed back by that tag, and the tag is stripped.
module vai_rd_arbiter #(
  parameter int unsigned NUM_SUB_AFUS    = 8,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned ALM_MARGIN      = 4,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic                           pClk,
  input  logic                           SoftReset,
  input  logic [NUM_SUB_AFUS-1:0]        afu_c0_valid,
  input  logic [NUM_SUB_AFUS-1:0][41:0]  afu_c0_addr,
  input  logic [NUM_SUB_AFUS-1:0][15:0]  afu_c0_mdata,
  input  logic [NUM_SUB_AFUS-1:0][41:0]  afu_offset,
  output logic [NUM_SUB_AFUS-1:0]        afu_c0_almfull,
  output logic                           up_c0_valid,
  output logic [41:0]                    up_c0_addr,
  output logic [15:0]                    up_c0_mdata,
  input  logic                           up_c0_almfull,
  input  logic                           up_rx_valid,
  input  logic [15:0]                    up_rx_mdata,
  input  logic [511:0]                   up_rx_data,
  output logic [NUM_SUB_AFUS-1:0]        afu_rx_valid,
  output logic [15:0]                    afu_rx_mdata,
  output logic [511:0]                   afu_rx_data,
  output logic [NUM_SUB_AFUS-1:0]        err_overflow,
  output logic                           err_bad_tag
);

  localparam int unsigned ID_W  = $clog2(NUM_SUB_AFUS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] FullLevel = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AlmLevel  = CNT_W'(FIFO_DEPTH - ALM_MARGIN);
  localparam logic [OUT_W-1:0] OutLimit  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [15:0]      TagMask   = ~(16'hffff >> ID_W);

  // Per-AFU FIFO storage (no reset needed: validity is tracked by the counts)
  logic [41:0] mem_addr  [NUM_SUB_AFUS][FIFO_DEPTH];
  logic [15:0] mem_mdata [NUM_SUB_AFUS][FIFO_DEPTH];

  logic [NUM_SUB_AFUS-1:0][PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [NUM_SUB_AFUS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SUB_AFUS-1:0][OUT_W-1:0] out_q, out_d;
  logic [ID_W-1:0]                    rr_ptr_q;

  logic [NUM_SUB_AFUS-1:0] eligible, grant, push_ok, overflow_set, rsp_hit, almfull_d;
  logic                    grant_any;
  logic [ID_W-1:0]         win_id, cand, rx_id;
  logic [31:0]             idx;
  logic [41:0]             rd_addr;
  logic [15:0]             rd_mdata;

  assign rx_id    = up_rx_mdata[15 -: ID_W];
  assign rd_addr  = mem_addr[win_id][rd_ptr_q[win_id]];
  assign rd_mdata = mem_mdata[win_id][rd_ptr_q[win_id]];

  // Per-AFU eligibility, push acceptance, response match and next counts
  always_comb begin
    eligible     = '0;
    push_ok      = '0;
    overflow_set = '0;
    rsp_hit      = '0;
    cnt_d        = cnt_q;
    out_d        = out_q;
    almfull_d    = '0;
    for (int unsigned n = 0; n < NUM_SUB_AFUS; n++) begin
      eligible[n] = (cnt_q[n] != '0) && (out_q[n] < OutLimit);
      // A full FIFO still accepts a push when it is popped in the same cycle
      push_ok[n]      = afu_c0_valid[n] && ((cnt_q[n] != FullLevel) || grant[n]);
      overflow_set[n] = afu_c0_valid[n] && !push_ok[n];
      rsp_hit[n]      = up_rx_valid && (rx_id == ID_W'(n)) && (out_q[n] != '0);
      if (push_ok[n] && !grant[n]) cnt_d[n] = cnt_q[n] + 1'b1;
      else if (!push_ok[n] && grant[n]) cnt_d[n] = cnt_q[n] - 1'b1;
      if (grant[n] && !rsp_hit[n]) out_d[n] = out_q[n] + 1'b1;
      else if (!grant[n] && rsp_hit[n]) out_d[n] = out_q[n] - 1'b1;
      almfull_d[n] = (cnt_d[n] >= AlmLevel) || (out_d[n] >= OutLimit);
    end
  end

  // Round-robin search: first eligible index at or after rr_ptr, wrapping
  always_comb begin
    grant_any = 1'b0;
    win_id    = '0;
    idx       = '0;
    cand      = '0;
    if (!up_c0_almfull) begin
      for (int unsigned i = 0; i < NUM_SUB_AFUS; i++) begin
        idx = 32'(rr_ptr_q) + i;
        if (idx >= NUM_SUB_AFUS) idx = idx - NUM_SUB_AFUS;
        cand = ID_W'(idx);
        if (!grant_any && eligible[cand]) begin
          grant_any = 1'b1;
          win_id    = cand;
        end
      end
    end
  end

  // One-hot grant vector from the winner
  always_comb begin
    grant = '0;
    if (grant_any) grant[win_id] = 1'b1;
  end

  // FIFO storage writes
  always_ff @(posedge pClk) begin
    for (int unsigned n = 0; n < NUM_SUB_AFUS; n++) begin
      if (push_ok[n]) begin
        mem_addr[n][wr_ptr_q[n]]  <= afu_c0_addr[n];
        mem_mdata[n][wr_ptr_q[n]] <= afu_c0_mdata[n];
      end
    end
  end

  // Pointers, counters, round-robin pointer and all registered outputs
  always_ff @(posedge pClk or posedge SoftReset) begin
    if (SoftReset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      out_q          <= '0;
      rr_ptr_q       <= '0;
      afu_c0_almfull <= '0;
      up_c0_valid    <= 1'b0;
      up_c0_addr     <= '0;
      up_c0_mdata    <= '0;
      afu_rx_valid   <= '0;
      afu_rx_mdata   <= '0;
      afu_rx_data    <= '0;
      err_overflow   <= '0;
      err_bad_tag    <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < NUM_SUB_AFUS; n++) begin
        if (push_ok[n]) wr_ptr_q[n] <= wr_ptr_q[n] + PTR_W'(1);
        if (grant[n])   rd_ptr_q[n] <= rd_ptr_q[n] + PTR_W'(1);
      end
      cnt_q          <= cnt_d;
      out_q          <= out_d;
      afu_c0_almfull <= almfull_d;
      up_c0_valid    <= grant_any;
      if (grant_any) begin
        rr_ptr_q    <= (win_id == ID_W'(NUM_SUB_AFUS - 1)) ? '0 : win_id + 1'b1;
        up_c0_addr  <= rd_addr + afu_offset[win_id];
        up_c0_mdata <= {win_id, rd_mdata[15-ID_W:0]};
      end
      afu_rx_valid <= rsp_hit;
      if (rsp_hit != '0) begin
        afu_rx_mdata <= up_rx_mdata & ~TagMask;
        afu_rx_data  <= up_rx_data;
      end
      err_overflow <= err_overflow | overflow_set;
      err_bad_tag  <= err_bad_tag | (up_rx_valid && (rsp_hit == '0));
    end
  end

endmodule

// File: doc/vai_rd_arbiter.md
# vai_rd_arbiter

Parametrised c0 (read-request) arbiter and response router for the VAI multiplexing layer, sitting between NUM_SUB_AFUS sub-AFUs and the single upstream CCI-P port. Each AFU gets its own skid FIFO, per-AFU address offset translation and an outstanding-read limit. Requests are granted round-robin and tagged with the AFU index in the upper mdata bits. Read responses are routed back by that tag and the tag bits are cleared. Unlike the fixed pass-through mux, it enforces per-AFU fairness and credit, and it flags protocol errors.

## Interface
- NUM_SUB_AFUS, 8, number of sub-AFUs (2..16); ID_W = $clog2(NUM_SUB_AFUS)
- FIFO_DEPTH, 8, per-AFU request FIFO entries (power of 2, ≥4)
- ALM_MARGIN, 4, free-entry threshold for afu_c0_almfull (1..FIFO_DEPTH-1)
- MAX_OUTSTANDING, 64, per-AFU outstanding read limit (≥1)

Ports:
- pClk  in  1  clock
- SoftReset  in  1  reset, asynchronous, active-high
- afu_c0_valid  in  [NUM_SUB_AFUS-1:0]  read request valid
- afu_c0_addr  in  [NUM_SUB_AFUS-1:0][41:0]  AFU-relative line address
- afu_c0_mdata  in  [NUM_SUB_AFUS-1:0][15:0]  request mdata; bits [15:16-ID_W] must be 0
- afu_offset  in  [NUM_SUB_AFUS-1:0][41:0]  per-AFU base offset, quasi-static
- afu_c0_almfull  out  [NUM_SUB_AFUS-1:0]  per-AFU almost-full
- up_c0_valid  out  1  upstream read request valid
- up_c0_addr  out  42  translated address
- up_c0_mdata  out  16  tagged mdata
- up_c0_almfull  in  1  upstream almost-full
- up_rx_valid  in  1  upstream read response valid
- up_rx_mdata  in  16  response mdata (tagged)
- up_rx_data  in  512  response data
- afu_rx_valid  out  [NUM_SUB_AFUS-1:0]  routed response valid
- afu_rx_mdata  out  16  response mdata, tag bits cleared (shared bus)
- afu_rx_data  out  512  response data (shared bus)
- err_overflow  out  [NUM_SUB_AFUS-1:0]  sticky: push into full FIFO
- err_bad_tag  out  1  sticky: response tag ≥ NUM_SUB_AFUS or to an AFU with 0 outstanding

## Operation
- Push: afu_c0_valid[n] writes {addr, mdata} into FIFO n. If FIFO n is full, the request is dropped and err_overflow[n] is set.
- afu_c0_almfull[n] = (fifo_count[n] ≥ FIFO_DEPTH−ALM_MARGIN) OR (outstanding[n] ≥ MAX_OUTSTANDING). It is registered from the current-cycle counts.
- Eligible[n] = FIFO n non-empty AND outstanding[n] < MAX_OUTSTANDING.
- Arbitration: no grant while up_c0_almfull=1. Otherwise grant the first eligible index at or after rr_ptr, wrapping modulo NUM_SUB_AFUS. After a grant, rr_ptr ← winner+1 (wraps). At most one grant per cycle.
- On a grant to n:
  - pop FIFO n
  - up_c0_addr = addr + afu_offset[n], modulo 2^42
  - up_c0_mdata = {n[ID_W-1:0], mdata[15−ID_W:0]}
  - outstanding[n]++
- Response handling: id = up_rx_mdata[15:16-ID_W].
  - If id < NUM_SUB_AFUS and outstanding[id] > 0: assert afu_rx_valid[id], drive afu_rx_mdata with the tag bits zeroed, drive afu_rx_data, and decrement outstanding[id].
  - Otherwise: drop the response, set err_bad_tag, and leave the counters unchanged.
- Grant and response for the same AFU in the same cycle: outstanding unchanged. Push and pop on the same FIFO in the same cycle, including when full: count unchanged, no overflow.
- Counter widths: outstanding is $clog2(MAX_OUTSTANDING+1) bits and never wraps. FIFO count is $clog2(FIFO_DEPTH)+1 bits.
- No state machine beyond rr_ptr, FIFO pointers and counters.

## Timing
- Request latency: push at cycle t, grant at t+1 at the earliest, up_c0_valid registered at t+2.
- Response latency: up_rx_valid at t → afu_rx_* registered at t+1.
- afu_c0_almfull reflects the pushes/pops of cycle t at t+1. An AFU may issue up to ALM_MARGIN further requests after seeing it without overflow.
- up_c0_almfull sampled at t blocks the grant at t; up_c0_valid is then low at t+1.
- Reset (async, any cycle): FIFOs empty, outstanding=0, rr_ptr=0, all outputs 0 (afu_c0_almfull=0, up_c0_valid=0, afu_rx_valid=0, error bits 0). In-flight requests and responses are discarded. Errors clear only on reset.

## Test plan
- Single AFU 3, offset 0x1000, addr 0x20, mdata 0x0005, N=8 → two cycles later up_c0_addr=0x1020, up_c0_mdata=0x6005. Response mdata 0x6005 → afu_rx_valid[3], afu_rx_mdata=0x0005, outstanding[3] back to 0.
- All 8 AFUs hold 4 requests each, no almfull → grants in order 0,1,…,7,0,… One up_c0_valid per cycle, 32 consecutive cycles.
- MAX_OUTSTANDING=2, AFU 0 pushes 4, no responses → exactly 2 granted and afu_c0_almfull[0]=1. One response → exactly 1 more grant.
- up_c0_almfull held high 10 cycles with 8 pushes to AFU 1 → no up_c0_valid. afu_c0_almfull[1]=1 once count ≥4. A 9th push sets err_overflow[1]. Release → 8 grants.
- Response tag 0xF000 with N=8 (id 7, outstanding 0) → no afu_rx_valid, err_bad_tag=1. Same-cycle grant and response on AFU 2 → outstanding[2] unchanged.
- SoftReset asserted mid-burst with FIFOs partly full → outputs 0 asynchronously. After release, no grants until new pushes; rr_ptr restarts at 0.
